i2s_tx_stereo: RTL and testbench

- Parametrised stereo I2S master transmitter; successor to the single-word 16-bit `i2s` serializer.
- Accepts left/right sample pairs over a valid/ready stream into a one-entry holding buffer. Generates bclk and lrclk from the system clock and serializes frames continuously.
- Adds configurable sample/slot width, a clock divider, runtime I2S/left-justified mode, underrun handling and clean stop at frame boundaries.
- Sits between the audio sample source and the external codec/DAC pins.

---
 rtl/i2s_tx_stereo.sv | 120 ++++++++++++
 tb/tb_i2s_tx_stereo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: stereo I2S / left-justified master transmitter with a one-entry sample buffer
// Ports: sys_clk_i/sys_rst_i (async active-low) clock and reset; en_i run enable;
// mode_i 0=I2S 1=left-justified; s_valid_i/s_ready_o/s_left_i/s_right_i sample stream;
// busy_o running; underrun_o empty buffer at frame start; bclk_o/lrclk_o/dout_o codec pins.
module i2s_tx_stereo #(
  parameter int DATA_W  = 16,
  parameter int SLOT_W  = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_left_i,
  input  logic [DATA_W-1:0] s_right_i,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              dout_o
);
  localparam int FW  = 2 * SLOT_W;
  localparam int BW  = $clog2(FW);
  localparam int DW  = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PAD = SLOT_W - DATA_W;
  typedef enum logic {IDLE, RUN} state_e;
  state_e              state_q, state_d;
  logic [DW-1:0]       d_q, d_d;
  logic [BW-1:0]       b_q, b_d;
  logic                bclk_q, bclk_d, lrclk_q, lrclk_d, dout_q, dout_d;
  logic                mode_q, mode_d, under_q, under_d, full_q, full_d;
  logic [2*DATA_W-1:0] hold_q, hold_d;
  logic [FW-1:0]       sr_q, sr_d, frame;
  logic                accept, tick, fall, wrap, load;
  assign s_ready_o  = ~full_q;
  assign accept     = s_valid_i & ~full_q;
  // Each sample is MSB-aligned in its slot; the low PAD bits stay zero.
  assign frame      = {SLOT_W'(hold_q[2*DATA_W-1:DATA_W]) << PAD, SLOT_W'(hold_q[DATA_W-1:0]) << PAD};
  assign tick       = state_q == RUN && d_q == DW'(CLK_DIV - 1);
  assign fall       = tick & bclk_q;
  assign wrap       = fall && b_q == BW'(FW - 1);
  assign load       = en_i & ((state_q == IDLE) | wrap);
  assign busy_o     = state_q == RUN;
  assign underrun_o = under_q;
  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign dout_o     = dout_q;
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    dout_d  = dout_q;
    sr_d    = sr_q;
    mode_d  = load ? mode_i : mode_q;
    under_d = load & ~full_q;
    full_d  = accept | (full_q & ~load);
    hold_d  = accept ? {s_left_i, s_right_i} : hold_q;
    if (state_q == IDLE) begin
      if (en_i) begin
        state_d = RUN;
        d_d     = '0;
        b_d     = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sr_d    = full_q ? frame : '0;
        // I2S starts with the (cleared) delay bit; left-justified shows the MSB at once.
        dout_d  = mode_i & sr_d[FW-1];
      end
    end else if (wrap && !en_i) begin
      state_d = IDLE;
      d_d     = '0;
      b_d     = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      dout_d  = 1'b0;
      sr_d    = '0;
    end else begin
      d_d    = tick ? '0 : d_q + DW'(1);
      bclk_d = bclk_q ^ tick;
      if (fall) begin
        b_d     = wrap ? '0 : b_q + BW'(1);
        sr_d    = wrap ? (full_q ? frame : '0) : sr_q << 1;
        lrclk_d = b_d >= BW'(SLOT_W);
        // The pre-shift MSB is the bit one bclk late, which is exactly the I2S delay.
        dout_d  = mode_d ? sr_d[FW-1] : sr_q[FW-1];
      end
    end
  end
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q <= IDLE;
      d_q     <= '0;
      b_q     <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      dout_q  <= 1'b0;
      mode_q  <= 1'b0;
      under_q <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      dout_q  <= dout_d;
      mode_q  <= mode_d;
      under_q <= under_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      sr_q    <= sr_d;
    end
  end
endmodule

// File: tb/tb_i2s_tx_stereo.sv
// tb_i2s_tx_stereo: scoreboard bench for i2s_tx_stereo (16-bit and 24-bit slot instances)
module tb_i2s_tx_stereo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, passed = 0, cyc = 0, t0 = 0, t1 = 0;
  int und_cnt_a = 0, und_cnt_b = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic en_a, mode_a, v_a, rdy_a, busy_a, und_a, bclk_a, lr_a, d_a;
  logic en_b, mode_b, v_b, rdy_b, busy_b, und_b, bclk_b, lr_b, d_b;
  logic [15:0] l_a, r_a, l_b, r_b;
  logic [1:0] qa[$], qb[$];
  logic [1:0] ea, eb;
  logic pa = 1'b0, pb = 1'b0, ua = 1'b0, ub = 1'b0;
  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2)) dut_a (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .en_i(en_a), .mode_i(mode_a),
    .s_valid_i(v_a), .s_ready_o(rdy_a), .s_left_i(l_a), .s_right_i(r_a),
    .busy_o(busy_a), .underrun_o(und_a), .bclk_o(bclk_a), .lrclk_o(lr_a), .dout_o(d_a)
  );
  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(24), .CLK_DIV(2)) dut_b (
    .sys_clk_i(clk), .sys_rst_i(rst_n), .en_i(en_b), .mode_i(mode_b),
    .s_valid_i(v_b), .s_ready_o(rdy_b), .s_left_i(l_b), .s_right_i(r_b),
    .busy_o(busy_b), .underrun_o(und_b), .bclk_o(bclk_b), .lrclk_o(lr_b), .dout_o(d_b)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask
  function automatic logic cond(input int w);
    case (w)
      0: return rdy_a;
      1: return rdy_b;
      2: return !busy_a;
      3: return !busy_b;
      default: return und_a;
    endcase
  endfunction
  task automatic wait_for(input int w, input int lim, input string name);
    int n = 0;
    while (cond(w) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, cond(w), 1);
  endtask
  // Expected {lrclk, dout} seen at each bclk rising edge for one frame word f.
  task automatic exp_frame(input bit sel, input logic [47:0] f, input int fw, input logic mode, input logic prev);
    logic [47:0] t;
    logic [1:0] e;
    for (int b = 0; b < fw; b++) begin
      t = mode ? f >> (fw - 1 - b) : (b == 0 ? {47'd0, prev} : f >> (fw - b));
      e = {b >= fw / 2, t[0]};
      if (sel) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask
  task automatic push(input bit sel, input logic [15:0] l, input logic [15:0] r);
    wait_for(sel ? 1 : 0, 400, "ready_before_push");
    if (sel) begin
      v_b = 1'b1; l_b = l; r_b = r;
    end else begin
      v_a = 1'b1; l_a = l; r_a = r;
    end
    @(negedge clk);
    v_a = 1'b0;
    v_b = 1'b0;
    check(sel ? "b_ready_after_push" : "a_ready_after_push", sel ? rdy_b : rdy_a, 0);
  endtask
  always @(negedge clk) begin
    if (busy_a && bclk_a && !pa) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_extra_bit: got dout %b, expected no bit", d_a);
      end else begin
        ea = qa.pop_front();
        check("a_lrclk", lr_a, ea[1]);
        check("a_dout", d_a, ea[0]);
      end
    end
    if (und_a && ua) begin
      total++;
      $display("FAIL a_underrun_width: got multi-cycle pulse, expected 1 cycle");
    end
    if (und_a) und_cnt_a++;
    pa <= bclk_a;
    ua <= und_a;
  end
  always @(negedge clk) begin
    if (busy_b && bclk_b && !pb) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_extra_bit: got dout %b, expected no bit", d_b);
      end else begin
        eb = qb.pop_front();
        check("b_lrclk", lr_b, eb[1]);
        check("b_dout", d_b, eb[0]);
      end
    end
    if (und_b && ub) begin
      total++;
      $display("FAIL b_underrun_width: got multi-cycle pulse, expected 1 cycle");
    end
    if (und_b) und_cnt_b++;
    pb <= bclk_b;
    ub <= und_b;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    {en_a, mode_a, v_a, en_b, mode_b, v_b} = '0;
    {l_a, r_a, l_b, r_b} = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bclk_a, lr_a, d_a, busy_a, und_a}, 0);
    check("reset_ready", rdy_a, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {bclk_a, lr_a, d_a, busy_a, und_a, bclk_b, lr_b, d_b, busy_b, und_b}, 0);
    mode_a = 1'b1;
    exp_frame(0, 48'hA050_1234, 32, 1'b1, 1'b0);
    push(0, 16'hA050, 16'h1234);
    en_a = 1'b1;
    @(negedge clk);
    check("a_busy_on_entry", busy_a, 1);
    check("a_lj_msb_latency", d_a, 1);
    mode_a = 1'b0;
    exp_frame(0, 48'hA050_1234, 32, 1'b0, 1'b0);
    push(0, 16'hA050, 16'h1234);
    exp_frame(0, 48'h0, 32, 1'b0, 1'b0);
    wait_for(4, 400, "a_underrun_seen");
    t0 = cyc;
    @(negedge clk);
    check("a_underrun_one_cycle", und_a, 0);
    exp_frame(0, 48'hAAAA_7777, 32, 1'b0, 1'b0);
    push(0, 16'hAAAA, 16'h7777);
    wait_for(0, 200, "a_frame4_load");
    check("a_frame_len", cyc - t0, 128);
    exp_frame(0, 48'h0, 32, 1'b0, 1'b1);
    push(0, 16'h0000, 16'h0000);
    wait_for(0, 200, "a_frame5_load");
    t1 = cyc;
    repeat (40) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check("a_busy_after_en_drop", busy_a, 1);
    wait_for(2, 200, "a_stop");
    check("a_stop_at_boundary", cyc - t1, 128);
    check("a_stop_outputs", {bclk_a, lr_a, d_a, und_a}, 0);
    check("a_queue_drained", qa.size(), 0);
    check("a_underrun_count", und_cnt_a, 1);
    check("a_ready_idle", rdy_a, 1);
    mode_b = 1'b1;
    exp_frame(1, 48'hFFFF00_FFFF00, 48, 1'b1, 1'b0);
    push(1, 16'hFFFF, 16'hFFFF);
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    wait_for(3, 500, "b_stop");
    check("b_queue_drained", qb.size(), 0);
    check("b_underrun_count", und_cnt_b, 0);
    check("b_stop_outputs", {bclk_b, lr_b, d_b, und_b}, 0);
    mode_a = 1'b1;
    exp_frame(0, 48'h1234_5678, 32, 1'b1, 1'b0);
    push(0, 16'h1234, 16'h5678);
    en_a = 1'b1;
    @(negedge clk);
    push(0, 16'hAAAA, 16'h5555);
    repeat (50) @(negedge clk);
    check("a_busy_midframe", busy_a, 1);
    check("a_full_midframe", rdy_a, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 qa.delete();
    check("a_reset_midframe_outputs", {bclk_a, lr_a, d_a, busy_a, und_a}, 0);
    check("a_reset_midframe_ready", rdy_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("a_idle_after_reset", {busy_a, bclk_a, d_a}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
